// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FWFT FIFO of any depth with count, threshold flags, sticky errors and flush
module sync_fifo_flags #(
  parameter int C_DEPTH         = 6,
  parameter int C_WIDTH         = 16,
  parameter int C_AFULL_THRESH  = 5,
  parameter int C_AEMPTY_THRESH = 1,
  localparam int CW = $clog2(C_DEPTH + 1),
  localparam int AW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_wen,
  input  logic [C_WIDTH-1:0] i_wr_data,
  output logic               o_full,
  output logic               o_almost_full,
  input  logic               i_ren,
  output logic [C_WIDTH-1:0] o_rd_data,
  output logic               o_empty,
  output logic               o_almost_empty,
  output logic [CW-1:0]      o_count,
  output logic               o_overflow,
  output logic               o_underflow
);
  logic [C_WIDTH-1:0] mem_q [C_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic wacc, racc;
  // Flags are pure decodes of the registered count; read data is the head slot, unregistered
  always_comb begin
    o_count        = count_q;
    o_full         = count_q == CW'(C_DEPTH);
    o_empty        = count_q == '0;
    o_almost_full  = count_q >= CW'(C_AFULL_THRESH);
    o_almost_empty = count_q <= CW'(C_AEMPTY_THRESH);
    o_overflow     = ovf_q;
    o_underflow    = unf_q;
    o_rd_data      = mem_q[rd_ptr_q];
  end
  // Accept logic, wrap-by-compare pointer advance, count update; flush overrides requests without flagging errors
  always_comb begin
    wacc     = i_wen & ~o_full & ~i_flush;
    racc     = i_ren & ~o_empty & ~i_flush;
    wr_ptr_d = i_flush ? '0 : wacc ? ((wr_ptr_q == AW'(C_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = i_flush ? '0 : racc ? ((rd_ptr_q == AW'(C_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = i_flush ? '0 : count_q + CW'(wacc) - CW'(racc);
    ovf_d    = ovf_q | (i_wen & o_full & ~i_flush);
    unf_d    = unf_q | (i_ren & o_empty & ~i_flush);
  end
  // Control state with asynchronous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  // Storage is never reset; only accepted writes land
  always_ff @(posedge i_clk) begin
    if (wacc) mem_q[wr_ptr_q] <= i_wr_data;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: queue-model checked bench for sync_fifo_flags with directed vectors
module tb_sync_fifo_flags;
  localparam int D  = 6;
  localparam int W  = 16;
  localparam int AF = 5;
  localparam int AE = 1;
  localparam int CW = $clog2(D + 1);
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wen = 1'b0, ren = 1'b0;
  logic [W-1:0] wdata = '0;
  logic full, afull, empty, aempty, ovf, unf;
  logic [W-1:0] rdata;
  logic [CW-1:0] count;
  int total = 0, bad = 0;
  logic [W-1:0] mq [$];
  bit m_ovf, m_unf, m_full, m_empty;

  sync_fifo_flags #(.C_DEPTH(D), .C_WIDTH(W), .C_AFULL_THRESH(AF), .C_AEMPTY_THRESH(AE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_wen(wen), .i_wr_data(wdata),
    .o_full(full), .o_almost_full(afull), .i_ren(ren), .o_rd_data(rdata),
    .o_empty(empty), .o_almost_empty(aempty), .o_count(count),
    .o_overflow(ovf), .o_underflow(unf));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference behaviour: a queue holding the FIFO contents plus the two sticky bits
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_full  = mq.size() == D;
      m_empty = mq.size() == 0;
      if (wen && m_full) m_ovf = 1;
      if (ren && m_empty) m_unf = 1;
      if (ren && !m_empty) void'(mq.pop_front());
      if (wen && !m_full) mq.push_back(wdata);
    end
  end

  // Every cycle, away from the active edge, the DUT must agree with the model
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == D));
    chk("almost_full", 32'(afull), 32'(mq.size() >= AF));
    chk("almost_empty", 32'(aempty), 32'(mq.size() <= AE));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(unf), 32'(m_unf));
    chk("full_empty_excl", 32'(full && empty), 32'(0));
    chk("count_range", 32'(count <= CW'(D)), 32'(1));
    if (mq.size() > 0) chk("rd_data", 32'(rdata), 32'(mq[0]));
  end

  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic f);
    wen = w; wdata = d; ren = r; flush = f;
    @(posedge clk);
    #1;
    wen = 0; ren = 0; flush = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_aempty", 32'(aempty), 32'(1));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_afull", 32'(afull), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    chk("rst_unf", 32'(unf), 32'(0));
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // Put some state in, then reset mid-cycle and see it clear without an edge
    step(1, 16'h5555, 0, 0);
    step(1, 16'h6666, 0, 0);
    step(0, 0, 1, 0);
    step(1, 16'h7777, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 16'h8888, 0, 0);
    do_reset();
    // Fill to full, then one rejected write
    for (int i = 0; i < 7; i++) begin
      step(1, 16'hA000 + 16'(i), 0, 0);
      if (i == 3) chk("fill_afull_lo", 32'(afull), 32'(0));
      if (i == 4) chk("fill_afull_hi", 32'(afull), 32'(1));
      if (i == 4) chk("fill_full_lo", 32'(full), 32'(0));
      if (i == 5) chk("fill_full_hi", 32'(full), 32'(1));
    end
    chk("fill_ovf", 32'(ovf), 32'(1));
    chk("fill_count", 32'(count), 32'(6));
    for (int i = 0; i < 6; i++) begin
      chk("drain_data", 32'(rdata), 32'(16'hA000 + 16'(i)));
      step(0, 0, 1, 0);
    end
    chk("drain_empty", 32'(empty), 32'(1));
    // Hold occupancy at 3 while pointers wrap repeatedly
    for (int i = 0; i < 3; i++) step(1, 16'hB000 + 16'(i), 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 16'hC000 + 16'(i), 1, 0);
      chk("wrap_count", 32'(count), 32'(3));
    end
    chk("wrap_head", 32'(rdata), 32'(16'hC009));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("wrap_empty", 32'(empty), 32'(1));
    // Empty edge: lone read underflows, then read+write at empty admits only the write
    step(0, 0, 1, 0);
    chk("empty_unf", 32'(unf), 32'(1));
    chk("empty_count", 32'(count), 32'(0));
    step(1, 16'h1234, 1, 0);
    chk("empty_rw_count", 32'(count), 32'(1));
    chk("empty_rw_data", 32'(rdata), 32'(16'h1234));
    // Full edge from clean flags
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 16'hD000 + 16'(i), 0, 0);
    chk("full_pre_ovf", 32'(ovf), 32'(0));
    step(1, 16'hDEAD, 1, 0);
    chk("full_rw_count", 32'(count), 32'(5));
    chk("full_rw_ovf", 32'(ovf), 32'(1));
    chk("full_rw_head", 32'(rdata), 32'(16'hD001));
    // Flush at count 4 with both requests: requests dropped, sticky flags kept
    step(0, 0, 1, 0);
    chk("pre_flush_count", 32'(count), 32'(4));
    step(1, 16'hEEEE, 1, 1);
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_empty", 32'(empty), 32'(1));
    chk("flush_ovf", 32'(ovf), 32'(1));
    chk("flush_unf", 32'(unf), 32'(0));
    step(0, 0, 1, 1);
    chk("flush_empty_read_unf", 32'(unf), 32'(0));
    step(1, 16'hE000, 0, 0);
    chk("post_flush_count", 32'(count), 32'(1));
    chk("post_flush_data", 32'(rdata), 32'(16'hE000));
    step(1, 16'hE001, 1, 0);
    chk("post_flush_next", 32'(rdata), 32'(16'hE001));
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO. Generalises the team's gray-pointer FIFO for same-domain buffering between pipeline stages.
- Supports any depth, not only powers of two. Read side is first-word-fall-through.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush.

Parameters:
- C_DEPTH, 6, number of entries; any integer >= 1.
- C_WIDTH, 16, data width in bits.
- C_AFULL_THRESH, 5, o_almost_full asserts when count >= this value; legal range 1..C_DEPTH.
- C_AEMPTY_THRESH, 1, o_almost_empty asserts when count <= this value; legal range 0..C_DEPTH-1.
- Derived, not overridable: CW = $clog2(C_DEPTH+1), the count width; AW = max(1, $clog2(C_DEPTH)), the pointer width.

Ports:
- i_clk  in  1  sole clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush; empties the FIFO.
- i_wen  in  1  write request.
- i_wr_data  in  C_WIDTH  write data.
- o_full  out  1  count == C_DEPTH.
- o_almost_full  out  1  count >= C_AFULL_THRESH.
- i_ren  in  1  read request; pops the head entry.
- o_rd_data  out  C_WIDTH  head entry; valid whenever o_empty == 0.
- o_empty  out  1  count == 0.
- o_almost_empty  out  1  count <= C_AEMPTY_THRESH.
- o_count  out  CW  current occupancy.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset: one clock, asynchronous active-low reset (i_rst_n). Assertion immediately clears wr_ptr, rd_ptr, count, o_overflow and o_underflow, with no clock edge required.
- Output values in reset: o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_count=0.
- Memory contents are not reset. o_rd_data is don't-care while empty.
- Deassertion is synchronised externally. The first edge with i_rst_n=1 is a normal operating edge.
- Write accept: wacc = i_wen & ~o_full & ~i_flush. On accept, mem[wr_ptr] <= i_wr_data and wr_ptr advances.
- Read accept: racc = i_ren & ~o_empty & ~i_flush. On accept, rd_ptr advances.
- Pointer wrap: pointers run 0..C_DEPTH-1 and wrap to 0 by explicit compare, not modulo-2^AW.
- Count update: count <= count + wacc - racc.
- Flags: all are combinational decodes of the registered count and change in the cycle after the accepting edge. There are no extra register stages.
- Full + simultaneous rd/wr: the write is rejected and overflow sets. The read is accepted, so count drops by 1.
- Empty + simultaneous rd/wr: the read is rejected and underflow sets. The write is accepted, so count becomes 1 and the word appears on o_rd_data after that edge (FWFT).
- Simultaneous accepted read and write (neither full nor empty): count is unchanged and both pointers advance.
- C_DEPTH=1: a single slot. full = ~empty.
- Read data latency: o_rd_data = mem[rd_ptr], read combinationally. Zero-cycle latency from a pointer change; the next entry is visible in the cycle after a pop.
- Flush: on an edge with i_flush=1, wr_ptr, rd_ptr and count go to 0. Flush takes priority over i_wen/i_ren in the same cycle; those requests are dropped without setting the error flags.
- Sticky flags are unaffected by flush. They clear only on reset.
- Error flag timing: o_overflow sets at the edge where i_wen=1, o_full=1 and i_flush=0. o_underflow sets at the edge where i_ren=1, o_empty=1 and i_flush=0.
- Invariants the bench checks every cycle:
  - o_full and o_empty are never both 1.
  - o_count <= C_DEPTH.
  - Data order is strictly FIFO.

Test Plan:
- Reset: assert i_rst_n=0 mid-cycle -> outputs clear before the next edge: count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Fill: write 0xA000..0xA005 on consecutive cycles -> almost_full rises after the 5th write, full after the 6th. A 7th write is ignored, overflow=1, count stays 6. Read 6 times -> data 0xA000..0xA005 in order, then empty=1.
- Wrap: 12 single write/read pairs with count held near 3 (pointers wrap at 5->0 twice) -> every read matches the write order. Simultaneous rd/wr at count 3 leaves count=3.
- Empty edge: with empty, assert i_ren alone -> underflow=1, count 0. Then i_wen=1 and i_ren=1 with data 0x1234 -> count=1, o_rd_data=0x1234 on the next cycle.
- Full edge: with full, assert i_wen=1 and i_ren=1 -> read accepted, write dropped, count=5, overflow=1.
- Flush: at count 4 assert i_flush with i_wen=1 and i_ren=1 -> count=0, empty=1. Error flags keep their prior values. Normal writes resume on the next cycle.
